// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, TERC4 code table, FSM states
// and the 10b->8b video symbol decode.
package tmds_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Indexed by the 2-bit control code {c1,c0} the token carries.
    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Indexed by the decoded TERC4 nibble.
    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [7:0] tmds_decode_video(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] v;
        d    = q[9] ? ~q[7:0] : q[7:0];
        v[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return v;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_aligner.sv
// Word aligner: forms a 10-bit symbol window from the current and previous
// deserializer words at the selected bit offset, and advances that offset on slip.
module tmds_word_aligner (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [9:0]  i_sym,
    input  logic        i_slip,
    output logic [9:0]  o_win,
    output logic [3:0]  o_bit_offset,
    output logic [15:0] o_slip_cnt
);

    logic [9:0]  r_prev;
    logic [9:0]  r_win;
    logic [3:0]  r_offset;
    logic [15:0] r_slip_cnt;
    logic [19:0] w_pair;
    logic [19:0] w_shift;

    // Bit 0 is earliest, so the older word sits in the low half of the pair.
    assign w_pair  = {i_sym, r_prev};
    assign w_shift = w_pair >> r_offset;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_win      <= '0;
            r_offset   <= '0;
            r_slip_cnt <= '0;
        end else begin
            r_prev <= i_sym;
            r_win  <= w_shift[9:0];
            if (i_slip) begin
                r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                if (r_slip_cnt != 16'hFFFF) begin
                    r_slip_cnt <= r_slip_cnt + 16'd1;
                end
            end
        end
    end

    assign o_win        = r_win;
    assign o_bit_offset = r_offset;
    assign o_slip_cnt   = r_slip_cnt;

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: bit-slip alignment on control-token runs, then
// video/control decode. Optional TERC4 decode under TMDS_TERC4_DECODE_EN.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 12,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 2048
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [9:0]  sym_in,
    output logic [7:0]  data,
    output logic [1:0]  ctrl,
    output logic        de,
    output logic        ctrl_valid,
    output logic        locked,
    output logic [3:0]  bit_offset,
`ifdef TMDS_TERC4_DECODE_EN
    output logic [3:0]  terc4,
    output logic        terc4_valid,
`endif
    output logic [15:0] slip_cnt
);

    localparam int TMR_W = $clog2((SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT);
    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN);

    state_e           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [RUN_W-1:0] r_run_cnt;
    logic             r_slip_d;
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_de;
    logic             r_ctrl_valid;
    logic [9:0]       w_win;
    logic             w_is_tok;
    logic [1:0]       w_tok_code;
    logic             w_run_full;
    logic             w_slip;

    tmds_word_aligner u_aligner (
        .clk_pixel    (clk_pixel),
        .rst_n        (rst_n),
        .i_sym        (sym_in),
        .i_slip       (w_slip),
        .o_win        (w_win),
        .o_bit_offset (bit_offset),
        .o_slip_cnt   (slip_cnt)
    );

    always_comb begin
        w_is_tok   = 1'b0;
        w_tok_code = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (w_win == CTRL_TOKEN[i]) begin
                w_is_tok   = 1'b1;
                w_tok_code = 2'(i);
            end
        end
    end

    assign w_run_full = (r_run_cnt == RUN_FULL);
    assign w_slip     = (r_state == SEARCH) && !w_run_full && (r_tmr == SEARCH_LAST);

    // The window registered on the slip edge was still cut at the old offset,
    // so r_slip_d keeps it from being counted toward the new run.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SEARCH;
            r_tmr     <= '0;
            r_run_cnt <= '0;
            r_slip_d  <= 1'b0;
        end else begin
            r_slip_d <= w_slip;
            if (r_slip_d || !w_is_tok) begin
                r_run_cnt <= '0;
            end else if (!w_run_full) begin
                r_run_cnt <= r_run_cnt + RUN_W'(1);
            end
            case (r_state)
                SEARCH: begin
                    if (w_run_full) begin
                        r_state <= LOCKED;
                        r_tmr   <= '0;
                    end else if (w_slip) begin
                        r_tmr     <= '0;
                        r_run_cnt <= '0;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_run_full) begin
                        r_tmr <= '0;
                    end else if (r_tmr == LOCK_LAST) begin
                        r_state   <= SEARCH;
                        r_tmr     <= '0;
                        r_run_cnt <= '0;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_ctrl       <= '0;
            r_de         <= 1'b0;
            r_ctrl_valid <= 1'b0;
        end else if (r_state == LOCKED) begin
            if (w_is_tok) begin
                r_ctrl_valid <= 1'b1;
                r_de         <= 1'b0;
                r_ctrl       <= w_tok_code;
            end else begin
                r_ctrl_valid <= 1'b0;
                r_de         <= 1'b1;
                r_data       <= tmds_decode_video(w_win);
            end
        end else begin
            r_data       <= '0;
            r_ctrl       <= '0;
            r_de         <= 1'b0;
            r_ctrl_valid <= 1'b0;
        end
    end

`ifdef TMDS_TERC4_DECODE_EN
    logic       w_is_terc4;
    logic [3:0] w_terc4_code;
    logic [3:0] r_terc4;
    logic       r_terc4_valid;

    always_comb begin
        w_is_terc4   = 1'b0;
        w_terc4_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (w_win == TERC4_CODE[i]) begin
                w_is_terc4   = 1'b1;
                w_terc4_code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_terc4       <= '0;
            r_terc4_valid <= 1'b0;
        end else begin
            r_terc4_valid <= (r_state == LOCKED) && w_is_terc4;
            if ((r_state == LOCKED) && w_is_terc4) begin
                r_terc4 <= w_terc4_code;
            end
        end
    end

    assign terc4       = r_terc4;
    assign terc4_valid = r_terc4_valid;
`endif

    assign data       = r_data;
    assign ctrl       = r_ctrl;
    assign de         = r_de;
    assign ctrl_valid = r_ctrl_valid;
    assign locked     = (r_state == LOCKED);

endmodule
